dmem_responder: RTL and testbench

Data-memory responder on the far side of the core's data-memory port. It accepts one request per handshake from the memory stage: a byte address, 4-bit lane write-enable and write data. It performs a byte-lane-masked write or a full-word read on an internal synchronous RAM, then returns a single-cycle response. Configurable wait states let the core's stall logic be exercised against slow memory.

---
 rtl/dmem_responder_pkg.sv | 10 +
 rtl/dmem_ram_bank.sv | 22 ++
 rtl/dmem_responder.sv | 83 ++++++++
 tb/tb_dmem_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared state encodings and widths for the data-memory responder
package dmem_responder_pkg;
  typedef enum logic [1:0] {
    RESP_ST_IDLE = 2'd0,
    RESP_ST_WAIT = 2'd1,
    RESP_ST_RESP = 2'd2
  } resp_st_e;
  localparam int DMEM_LANES = 4;
  localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/dmem_ram_bank.sv
// dmem_ram_bank: byte-lane-writable synchronous RAM with registered read, storage only
module dmem_ram_bank
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DMEM_LANES-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  // read captures the word only on a read operation so it holds across write responses
  always_ff @(posedge clk) begin
    if (en && we == '0) rdata <= mem[addr];
    for (int l = 0; l < DMEM_LANES; l++)
      if (en && we[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshake FSM, wait-state counter and range check in front of dmem_ram_bank
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  resp_st_e state, state_d;
  logic [WAIT_CNT_W-1:0] cnt, cnt_d;
  logic [13:0] idx_q, op_idx;
  logic [3:0] we_q, op_we;
  logic [31:0] wdata_q, op_wdata, ram_q;
  logic in_wait, accept, op_fire, op_err, rd_sel;
  logic [1:0] addr_lo_unused;
  assign addr_lo_unused = req_addr[1:0];
  assign in_wait = state == RESP_ST_WAIT;
  assign req_ready = !in_wait;
  assign accept = req_valid && req_ready;
  assign resp_valid = state == RESP_ST_RESP;
  assign resp_rdata = rd_sel ? ram_q : '0;
  // with no wait states the operation uses the live request; otherwise the latched one
  assign op_idx = in_wait ? idx_q : req_addr[15:2];
  assign op_we = in_wait ? we_q : req_we;
  assign op_wdata = in_wait ? wdata_q : req_wdata;
  assign op_fire = in_wait ? cnt == '0 : accept && WAIT_CYCLES == 0;
  assign op_err = {1'b0, op_idx} >= 15'(DEPTH_WORDS);
  // next state and counter: wait counts down to zero, accepts restart the sequence
  always_comb begin
    state_d = RESP_ST_IDLE;
    cnt_d = cnt;
    if (in_wait) begin
      state_d = cnt == '0 ? RESP_ST_RESP : RESP_ST_WAIT;
      cnt_d = cnt == '0 ? cnt : cnt - WAIT_CNT_W'(1);
    end else if (accept) begin
      state_d = WAIT_CYCLES == 0 ? RESP_ST_RESP : RESP_ST_WAIT;
      cnt_d = WAIT_CYCLES == 0 ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);
    end
  end
  // state, counter, request latch and response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESP_ST_IDLE;
      cnt <= '0;
      idx_q <= '0;
      we_q <= '0;
      wdata_q <= '0;
      resp_err <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        idx_q <= req_addr[15:2];
        we_q <= req_we;
        wdata_q <= req_wdata;
      end
      if (op_fire) begin
        resp_err <= op_err;
        rd_sel <= !op_err && op_we == '0;
      end
    end
  end
  dmem_ram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk  (clk),
    .en   (op_fire && !op_err && !rst),
    .we   (op_we),
    .addr (op_idx[AW-1:0]),
    .wdata(op_wdata),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of three responders (0, 3 and 2 wait states)
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  logic valid [3];
  logic ready [3];
  logic rv [3];
  logic err [3];
  logic [15:0] addr [3];
  logic [3:0] we [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];
  logic [31:0] mm [3][1024];
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : 2)) u (
      .clk(clk), .rst(rst), .req_valid(valid[g]), .req_ready(ready[g]),
      .req_addr(addr[g]), .req_we(we[g]), .req_wdata(wd[g]),
      .resp_valid(rv[g]), .resp_rdata(rd[g]), .resp_err(err[g]));
  end
  function automatic int wc(int i);
    return i == 0 ? 0 : i == 1 ? 3 : 2;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle(int n);
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) chk("idle_no_pulse", rv[i], 0);
    end
  endtask
  task automatic req(int i, logic [15:0] a, logic [3:0] w, logic [31:0] d, bit hold = 0);
    logic [31:0] ed;
    logic ee;
    int n, idx;
    valid[i] = 1'b1; addr[i] = a; we[i] = w; wd[i] = d;
    n = 0;
    while (ready[i] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept", ready[i], 1);
    idx = int'(a) / 4;
    ee = idx >= 1024;
    ed = 0;
    if (!ee && w != 0) begin
      for (int b = 0; b < 4; b++) if (w[b]) mm[i][idx][8*b +: 8] = d[8*b +: 8];
    end else if (!ee) ed = mm[i][idx];
    @(posedge clk); #1;
    if (!hold) valid[i] = 1'b0;
    for (int k = 0; k < wc(i); k++) begin
      chk("wait_ready_low", ready[i], 0);
      chk("wait_no_resp", rv[i], 0);
      @(posedge clk); #1;
    end
    chk("resp_valid", rv[i], 1);
    chk("resp_rdata", rd[i], ed);
    chk("resp_err", err[i], ee);
  endtask
  task automatic abort_write(int delay);
    valid[2] = 1'b1; addr[2] = 16'h0004; we[2] = 4'hF; wd[2] = 32'hDEADBEEF;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    chk("abort_in_wait", ready[2], 0);
    for (int k = 0; k < delay; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_idle", ready[2], 1);
    chk("abort_no_resp", rv[2], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
  endtask
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; addr[i] = '0; we[i] = '0; wd[i] = '0;
    end
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_resp_valid", rv[i], 0);
      chk("rst_rdata", rd[i], 0);
      chk("rst_err", err[i], 0);
      chk("rst_ready", ready[i], 1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    req(0, 16'h0010, 4'hF, 32'h11223344);
    idle(1);
    req(0, 16'h0010, 4'h0, 32'h0);
    idle(1);
    req(0, 16'h0010, 4'b0001, 32'hFFFFFFAB);
    req(0, 16'h0011, 4'h0, 32'h0);
    req(0, 16'h0010, 4'b0011, 32'h0000BEEF);
    req(0, 16'h0013, 4'h0, 32'h0);
    idle(1);
    req(0, 16'h0000, 4'hF, 32'hCAFEF00D);
    req(0, 16'h1000, 4'hF, 32'h12345678);
    req(0, 16'h0000, 4'h0, 32'h0);
    req(0, 16'hFFFC, 4'h0, 32'h0);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      req(0, 16'h0020, 4'hF, $urandom);
      req(0, 16'h0020, 4'h0, 32'h0);
    end
    idle(2);
    req(1, 16'h0030, 4'hF, 32'h0BADCAFE);
    idle(1);
    req(1, 16'h0030, 4'h0, 32'h0, 1);
    req(1, 16'h0030, 4'h0, 32'h0);
    idle(2);
    req(2, 16'h0004, 4'hF, 32'hAAAA5555);
    idle(1);
    abort_write(0);
    req(2, 16'h0004, 4'h0, 32'h0);
    idle(1);
    abort_write(1);
    req(2, 16'h0004, 4'h0, 32'h0);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 8; w++) req(i, 16'(16'h0040 + 4 * w), 4'hF, $urandom);
      for (int k = 0; k < 30; k++) begin
        logic [15:0] a;
        logic [3:0] w;
        a = $urandom_range(0, 9) == 0 ? 16'(16'h1000 + $urandom_range(0, 16'hEFFF))
                                      : 16'(16'h0040 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
        w = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
        req(i, a, w, $urandom);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
